// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - first-word-fall-through 24-bit pixel FIFO between frame fetch and VGA timing
// Optional sticky overflow/underflow debug flags are built when PIXEL_FIFO_ERR_EN is defined.
module pixel_fifo #(
    parameter int DATA_W       = 24,
    parameter int DEPTH_LOG2   = 6,
    parameter int AFULL_THRESH = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_LVL = (DEPTH_LOG2+1)'(AFULL_THRESH);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    // Status flags decode only from the registered occupancy; no lookahead.
    assign empty       = (level == '0);
    assign full        = (level == DEPTH_LVL);
    assign almost_full = (level >= AFULL_LVL);

    // Head entry falls through combinationally; meaningless while empty.
    assign rd_data = mem[rptr];

    // Pointer and occupancy state; reset discards all queued pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Pixel storage; contents are intentionally left untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= wr_data;
        end
    end

`ifdef PIXEL_FIFO_ERR_EN
    logic ovf_q;
    logic unf_q;

    // Sticky debug flags; a new event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_en && full && !rd_acc) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (rd_en && empty) begin
                unf_q <= 1'b1;
            end else if (clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_fifo.sv
// tb/tb_pixel_fifo.sv - self-checking bench for pixel_fifo against a queue-based reference model
module tb_pixel_fifo;

`ifdef PIXEL_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [23:0] wr_data;
    logic        rd_en;
    logic [23:0] rd_data;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic [6:0]  level;
    logic        overflow;
    logic        underflow;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    logic [23:0] q[$];
    bit          m_ovf;
    bit          m_unf;

    pixel_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ":level"}, 32'(level), 32'(q.size()));
        check({tag, ":empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ":full"}, 32'(full), 32'(q.size() == 64));
        check({tag, ":almost_full"}, 32'(almost_full), 32'(q.size() >= 56));
        check({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ":underflow"}, 32'(underflow), 32'(m_unf));
        if (q.size() != 0) begin
            check({tag, ":rd_data"}, 32'(rd_data), 32'(q[0]));
        end
    endtask

    task automatic step(input string tag, input logic we, input logic [23:0] wd,
                        input logic re, input logic ce);
        bit m_full;
        bit m_empty;
        bit racc;
        bit wacc;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clr_err = ce;
        m_full  = (q.size() == 64);
        m_empty = (q.size() == 0);
        racc    = re && !m_empty;
        wacc    = we && (!m_full || racc);
        @(posedge clk);
        if (racc) void'(q.pop_front());
        if (wacc) q.push_back(wd);
        if (ERR_EN) begin
            if (ce) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (we && m_full && !racc) m_ovf = 1'b1;
            if (re && m_empty) m_unf = 1'b1;
        end
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [23:0] d;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;
        step("idle", 1'b0, 24'h0, 1'b0, 1'b0);

        // Three primaries in, three out.
        step("w0", 1'b1, 24'hFF0000, 1'b0, 1'b0);
        check("first_head", 32'(rd_data), 32'h00FF0000);
        step("w1", 1'b1, 24'h00FF00, 1'b0, 1'b0);
        step("w2", 1'b1, 24'h0000FF, 1'b0, 1'b0);
        step("p0", 1'b0, 24'h0, 1'b1, 1'b0);
        check("seq_1", 32'(rd_data), 32'h0000FF00);
        step("p1", 1'b0, 24'h0, 1'b1, 1'b0);
        check("seq_2", 32'(rd_data), 32'h000000FF);
        step("p2", 1'b0, 24'h0, 1'b1, 1'b0);
        check("empty_after_3", 32'(empty), 32'd1);

        // Fill to 64 distinct values.
        for (int i = 0; i < 64; i++) begin
            d = {8'(i), 16'($urandom)};
            step("fill", 1'b1, d, 1'b0, 1'b0);
            if (i == 54) check("af_low_55", 32'(almost_full), 32'd0);
            if (i == 55) check("af_at_56", 32'(almost_full), 32'd1);
            if (i == 62) check("not_full_63", 32'(full), 32'd0);
        end
        check("full_64", 32'(full), 32'd1);
        step("write65", 1'b1, 24'hABCDEF, 1'b0, 1'b0);
        check("ovf_65", 32'(overflow), 32'(ERR_EN));
        check("level_65", 32'(level), 32'd64);
        step("clr_ovf", 1'b0, 24'h0, 1'b0, 1'b1);

        // Simultaneous push and pop while full.
        for (int i = 0; i < 10; i++) begin
            step("full_both", 1'b1, 24'($urandom), 1'b1, 1'b0);
        end
        check("full_both_level", 32'(level), 32'd64);
        check("full_both_ovf", 32'(overflow), 32'd0);

        // Drain in order across the pointer wrap.
        for (int i = 0; i < 64; i++) begin
            step("drain", 1'b0, 24'h0, 1'b1, 1'b0);
        end
        check("drained_empty", 32'(empty), 32'd1);

        // Read and write together on an empty FIFO: no bypass.
        step("unf_both", 1'b1, 24'h123456, 1'b1, 1'b0);
        check("unf_set", 32'(underflow), 32'(ERR_EN));
        check("unf_level", 32'(level), 32'd1);
        check("unf_head", 32'(rd_data), 32'h00123456);
        step("unf_clr", 1'b0, 24'h0, 1'b0, 1'b1);
        check("unf_cleared", 32'(underflow), 32'd0);
        step("unf_pop", 1'b0, 24'h0, 1'b1, 1'b0);

        // Clear coinciding with a new underflow keeps the flag set.
        step("set_wins", 1'b0, 24'h0, 1'b1, 1'b1);
        check("set_wins_unf", 32'(underflow), 32'(ERR_EN));
        step("clr2", 1'b0, 24'h0, 1'b0, 1'b1);

        // Randomized traffic: write-heavy, then read-heavy.
        for (int i = 0; i < 600; i++) begin
            if (i < 300) begin
                step("rand_a", ($urandom_range(0, 9) < 8), 24'($urandom),
                     ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
            end else begin
                step("rand_b", ($urandom_range(0, 9) < 3), 24'($urandom),
                     ($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0));
            end
        end

        // Asynchronous reset mid-stream.
        while (q.size() != 0) step("pre_drain", 1'b0, 24'h0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step("pre_rst", 1'b1, 24'($urandom), 1'b0, 1'b0);
        end
        check("level_20", 32'(level), 32'd20);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_empty", 32'(empty), 32'd1);
        check("async_level", 32'(level), 32'd0);
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b0, 24'h0, 1'b0, 1'b0);
        step("post_rst_w", 1'b1, 24'h5A5A5A, 1'b0, 1'b0);
        step("post_rst_r", 1'b0, 24'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
